// File: rtl/fetch_pkg.sv
// Shared fetch-side types: state encoding and buffered entry layout.
// Optional perf counters in the top are enabled by FETCH_PERF_CNT_EN.
package fetch_pkg;

   localparam int XLEN     = 32;
   localparam int ADDR_LSB = 2;

   typedef enum logic {
      RUN,
      FLUSH
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between memory capture and decode.
// Flush wins over push; pop alongside flush is harmless.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  fetch_entry_t  push_entry_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign do_push = push_i & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Entry storage; contents are masked by empty so no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator for a 1-cycle sync ROM, buffered to decode.
// Define FETCH_PERF_CNT_EN to add fetch/stall/flush counters.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q;
   logic [31:0]   pc_q;
   logic [31:0]   req_pc_q;
   logic          req_valid_q;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   logic          empty;
   logic          pop;
   logic          issue;
   logic [31:0]   pc_inc;
   logic [31:0]   redir_pc_d;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;

   assign pop        = inst_valid & inst_ready;
   assign occ        = {1'b0, count} + (CW+1)'(req_valid_q)
                       - (CW+1)'(pop);
   assign issue      = (state_q == RUN) & ~redirect_valid
                       & (occ < (CW+1)'(DEPTH));
   assign pc_inc     = pc_q + 32'd4;
   assign redir_pc_d = redirect_pc & ~32'h3;

   assign imem_addr  = {{ADDR_LSB{1'b0}}, pc_q[XLEN-1:ADDR_LSB]};
   assign push_entry = '{data: imem_rdata, pc: req_pc_q};
   assign inst_valid = ~empty;
   assign inst_data  = head.data;
   assign inst_pc    = head.pc;

   // Fetch FSM: redirect/flush sequencing, issue and PC advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         req_valid_q <= 1'b0;
      end else if (redirect_valid) begin
         state_q     <= FLUSH;
         pc_q        <= redir_pc_d;
         req_valid_q <= 1'b0;
      end else if (state_q == FLUSH) begin
         state_q     <= RUN;
         req_valid_q <= 1'b0;
      end else begin
         req_valid_q <= issue;
         if (issue) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_inc;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (req_valid_q),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .flush_i      (redirect_valid),
      .head_o       (head),
      .count_o      (count),
      .empty_o      (empty)
   );

`ifdef FETCH_PERF_CNT_EN
   // Free-running wrap-around event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (issue)
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (inst_valid & ~inst_ready)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (redirect_valid)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of pc/data.
// Perf counter checks are compiled in with FETCH_PERF_CNT_EN.
module tb_instr_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem [256];
   int          checks;
   int          errors;
   int          m_fetch;
   int          m_stall;
   int          m_flush;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous ROM, one cycle read latency.
   always @(posedge clk) begin
      imem_rdata <= mem[imem_addr[7:0]];
   end

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      logic [7:0] idx;
      idx = pc[9:2];
      return mem[idx];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc   = start + 32'(4 * i);
         e.data = word_at(e.pc);
         sb.push_back(e);
      end
   endtask

   // Score the handshake of the current cycle, then advance one cycle.
   task automatic tick();
      exp_t        e;
      logic [31:0] a0;
      logic        red;
      if (inst_valid && inst_ready) begin
         chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_pc", inst_pc, e.pc);
            chk("sb_data", inst_data, e.data);
         end
      end
      chk("no_push_full",
          32'(dut.u_fifo.push_i && int'(dut.u_fifo.count_o) == DEPTH),
          32'd0);
      if (inst_valid && !inst_ready) m_stall++;
      if (redirect_valid) m_flush++;
      a0  = imem_addr;
      red = redirect_valid;
      @(posedge clk);
      @(negedge clk);
      if (!red && imem_addr == a0 + 32'd1) m_fetch++;
   endtask

   task automatic do_reset(input logic rdy);
      rst_n          = 1'b0;
      inst_ready     = rdy;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_data", inst_data, 32'd0);
      chk("rst_pc", inst_pc, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      sb.delete();
      m_fetch = 0;
      m_stall = 0;
      m_flush = 0;
      rst_n   = 1'b1;
   endtask

   initial begin
      logic [31:0] prog [4];
      checks         = 0;
      errors         = 0;
      rst_n          = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h0080_0113;
      prog[2] = 32'h0100_0193;
      prog[3] = 32'h0000_8233;
      for (int i = 0; i < 4; i++) mem[i] = prog[i];

      // Streaming after reset with decode always ready.
      do_reset(1'b1);
      push_seq(32'h0, 6);
      tick();
      chk("s1_c1_valid", 32'(inst_valid), 32'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("s1_valid", 32'(inst_valid), 32'd1);
         chk("s1_pc", inst_pc, 32'(4 * k));
         chk("s1_data", inst_data, prog[k]);
         tick();
      end
      inst_ready = 1'b0;
      chk("s1_left", 32'(sb.size()), 32'd2);

      // Back-pressure from reset, then release and redirect to 0x1.
      do_reset(1'b0);
      push_seq(32'h0, 8);
      repeat (10) tick();
      chk("s2_count", 32'(dut.u_fifo.count_o), 32'd2);
      chk("s2_addr", imem_addr, 32'd2);
      chk("s2_pc", inst_pc, 32'd0);
      chk("s2_valid", 32'(inst_valid), 32'd1);
      inst_ready = 1'b1;
      tick();
      chk("s2_pc4_v", 32'(inst_valid), 32'd1);
      chk("s2_pc4", inst_pc, 32'd4);
      tick();
      chk("s2_pc8_v", 32'(inst_valid), 32'd1);
      chk("s2_pc8", inst_pc, 32'd8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0001;
      tick();
      redirect_valid = 1'b0;
      chk("s3_dropped", sb[0].pc, 32'hC);
      sb.delete();
      push_seq(32'h0, 4);
      for (int d = 1; d <= 3; d++) begin
         chk("s3_gap", 32'(inst_valid), 32'd0);
         tick();
      end
      chk("s3_valid", 32'(inst_valid), 32'd1);
      chk("s3_pc", inst_pc, 32'd0);
      chk("s3_data", inst_data, 32'h0050_0093);
      repeat (3) tick();
`ifdef FETCH_PERF_CNT_EN
      chk("perf_stall", perf_stall_cnt, 32'(m_stall));
      chk("perf_flush", perf_flush_cnt, 32'(m_flush));
      chk("perf_fetch", perf_fetch_cnt, 32'(m_fetch));
`endif
      inst_ready = 1'b0;

      // Back-to-back redirects: the later target wins.
      do_reset(1'b1);
      push_seq(32'h0, 8);
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0010;
      tick();
      sb.delete();
      redirect_pc = 32'h0000_0020;
      tick();
      redirect_valid = 1'b0;
      sb.delete();
      push_seq(32'h20, 4);
      for (int d = 1; d <= 3; d++) begin
         chk("s4_gap", 32'(inst_valid), 32'd0);
         tick();
      end
      chk("s4_valid", 32'(inst_valid), 32'd1);
      chk("s4_pc", inst_pc, 32'h20);
      chk("s4_data", inst_data, mem[8]);
      repeat (3) tick();

      // Asynchronous reset with a full buffer.
      do_reset(1'b0);
      repeat (5) tick();
      chk("s5_count", 32'(dut.u_fifo.count_o), 32'd2);
      chk("s5_pre_valid", 32'(inst_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("s5_async_valid", 32'(inst_valid), 32'd0);
      chk("s5_async_pc", inst_pc, 32'd0);
      chk("s5_async_data", inst_data, 32'd0);
      chk("s5_async_addr", imem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      push_seq(32'h0, 6);
      inst_ready = 1'b1;
      tick();
      tick();
      chk("s5_valid", 32'(inst_valid), 32'd1);
      chk("s5_pc", inst_pc, 32'd0);
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
